fpga_wrapper: RTL and testbench
===============================

// Module: fpga_wrapper
// PURPOSE
//  Board-level top for the FPGA build. Takes a differential board clock, an async reset and
//  3 external interrupt pins. Drives 8 status LEDs; optionally adds a UART that shows and echoes bytes.
//  Converts pins into clean internal clock/reset/events. Sits directly below the board constraints.
// PARAMETERS
//  BAUD_DIV     32  clocks per UART bit (200 MHz clock, 160 ns bit)
//  HB_W         26  heartbeat counter width
//  SYNC_STAGES  2   flops per synchronizer (>=2)
// PORTS
//  clk_in1_p  in   1  differential clock, positive leg (200 MHz)
//  clk_in1_n  in   1  differential clock, negative leg
//  rst_in     in   1  reset, asynchronous, active-low
//  int_in     in   3  async external interrupt request pins, active-high
//  led        out  8  status LEDs
//  srx_pad_i  in   1  UART receive pin, idle high (UART_PER_EN only)
//  stx_pad_o  out  1  UART transmit pin, idle high (UART_PER_EN only)
// BEHAVIOUR
//  Clock
//   - Single clock clk from the pair: differential input buffer in synthesis, clk_in1_p in simulation.
//  Reset
//   - rst_in low asserts internal rst asynchronously.
//   - Release is synchronous: SYNC_STAGES rising edges after rst_in goes high.
//   - All state below resets via rst.
//  Interrupts
//   - Each int_in[i] passes through SYNC_STAGES flops; a rising edge of the synced bit sets sticky int_pend[i].
//   - Pulses shorter than 1 clk may be missed. Edge and clear in the same cycle: set wins.
//  LEDs
//   - Registered. Reset value 8'h00.
//   - Without UART: led = {int_pend[2:0], hb[HB_W-1 -: 5]}. hb is a free-running wrap-around counter.
//  UART receiver (8N1, LSB first)
//   - srx is synced. A falling edge while idle starts reception.
//   - Start bit is re-checked at BAUD_DIV/2; if high, return to idle (glitch).
//   - Then 8 data bits and the stop bit are sampled every BAUD_DIV clocks.
//   - Stop bit = 0: framing error, byte dropped, led unchanged.
//   - Good byte: rx_byte <= data; one-cycle rx_valid.
//   - States: IDLE, START, DATA, STOP.
//  UART transmitter
//   - States: IDLE, START, DATA(8), STOP; BAUD_DIV clocks per bit; stx = 1 in IDLE and during reset.
//   - Request priority when IDLE: pending echo, then lowest pending int_pend bit i.
//   - Interrupt i sends 8'h30+i and clears int_pend[i] at transmit start.
//   - A byte received while busy is held in a 1-deep echo buffer; a newer one overwrites it.
// CONFIGURATION
//  UART_PER_EN defined:
//   - UART ports present.
//   - led = rx_byte (last good byte, reset 0).
//   - Interrupts are reported over tx.
//  UART_PER_EN undefined:
//   - No UART ports or logic.
//   - int_pend is never cleared except by reset.
//   - LED map as above.
// STRUCTURE
//  - Shared package: UART state enum, BAUD_DIV default, ASCII base 8'h30.
//  - One sub-module: sync_bit (parameterised SYNC_STAGES synchronizer), used for rst release, int_in, srx.
//  - UART rx/tx stay inline.
// TESTING
//  - rst_in=0 for 200 ns, then 1 -> led=0 and stx=1 throughout reset; rst deasserts 2 clks after release.
//  - No UART, int_in=3'b100 for 20 ns -> led[7]=1 within 4 clks; stays set until reset.
//  - No UART, 2^HB_W clks -> led[4:0] counts, wraps to 0.
//  - UART, srx frame 0x61 at 160 ns/bit, 500 ns gap, then 0x67 -> led=8'h61, then 8'h67; stx echoes 0x61, 0x67 in order.
//  - UART, frame with stop bit 0 -> led unchanged, no echo; 40 ns low glitch on srx -> no reception.
//  - UART, int_in=3'b011 pulsed while idle -> stx sends 8'h30, then 8'h31; int_pend clears.

Source files
------------

// File: rtl/fpga_wrapper_pkg.sv
// Shared definitions for the fpga_wrapper board top: UART state encoding,
// default bit period and the ASCII base used to report interrupts.
`timescale 1ns/1ps
package fpga_wrapper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    localparam int unsigned BAUD_DIV_DEFAULT = 32;
    localparam logic [7:0]  ASCII_BASE       = 8'h30;

    // Index of the lowest set bit; only called with a non-zero vector.
    function automatic logic [1:0] lowest_set(input logic [2:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else           return 2'd2;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset
// to a configurable value.
`timescale 1ns/1ps
module sync_bit #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= RST_VAL ? '1 : '0;
        else        sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/fpga_wrapper.sv
// Board-level top: clock/reset conditioning, synchronized sticky interrupts,
// status LEDs, and an optional echo/report UART enabled by UART_PER_EN.
`timescale 1ns/1ps
module fpga_wrapper
    import fpga_wrapper_pkg::*;
#(
    parameter int unsigned BAUD_DIV    = BAUD_DIV_DEFAULT,
    parameter int unsigned HB_W        = 26,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_in1_p,
    input  logic       clk_in1_n,
    input  logic       rst_in,
    input  logic [2:0] int_in,
`ifdef UART_PER_EN
    input  logic       srx_pad_i,
    output logic       stx_pad_o,
`endif
    output logic [7:0] led
);

    logic       clk;
    logic       rst_n;
    logic [2:0] int_sync;
    logic [2:0] int_sync_d;
    logic [2:0] int_pend;
    logic [2:0] int_clr;

`ifdef SYNTHESIS
    IBUFDS u_clk_ibuf (.I(clk_in1_p), .IB(clk_in1_n), .O(clk));
`else
    logic unused_clk_n;
    assign clk          = clk_in1_p;
    assign unused_clk_n = clk_in1_n;
`endif

    // Reset asserts immediately with rst_in, releases after SYNC_STAGES edges.
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rst_sync (
        .clk   (clk),
        .rst_n (rst_in),
        .d     (1'b1),
        .q     (rst_n)
    );

    for (genvar i = 0; i < 3; i++) begin : g_int_sync
        sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_int_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (int_in[i]),
            .q     (int_sync[i])
        );
    end

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_sync_d <= '0;
            int_pend   <= '0;
        end else begin
            int_sync_d <= int_sync;
            int_pend   <= (int_pend & ~int_clr) | (int_sync & ~int_sync_d);
        end
    end

`ifdef UART_PER_EN
    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam int unsigned hb_w_unused = HB_W;

    logic             srx_s, srx_d;
    uart_state_t      rx_state, rx_state_nx;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]       rx_bit, rx_bit_nx;
    logic [7:0]       rx_sh, rx_sh_nx;
    logic             rx_valid;
    logic [7:0]       rx_byte;

    uart_state_t      tx_state, tx_state_nx;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]       tx_bit, tx_bit_nx;
    logic [7:0]       tx_sh, tx_sh_nx;
    logic             stx_q, stx_nx;
    logic [1:0]       tx_irq_idx;
    logic             echo_valid, echo_take;
    logic [7:0]       echo_byte;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_srx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (srx_pad_i),
        .q     (srx_s)
    );

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_bit_nx   = rx_bit;
        rx_sh_nx    = rx_sh;
        rx_valid    = 1'b0;
        unique case (rx_state)
            ST_IDLE: if (srx_d && !srx_s) begin
                rx_state_nx = ST_START;
                rx_cnt_nx   = '0;
            end
            ST_START: if (rx_cnt == CNT_HALF) begin
                rx_cnt_nx   = '0;
                rx_bit_nx   = '0;
                rx_state_nx = srx_s ? ST_IDLE : ST_DATA;
            end else rx_cnt_nx = rx_cnt + 1'b1;
            ST_DATA: if (rx_cnt == CNT_FULL) begin
                rx_cnt_nx = '0;
                rx_sh_nx  = {srx_s, rx_sh[7:1]};
                rx_bit_nx = rx_bit + 1'b1;
                if (rx_bit == 3'd7) rx_state_nx = ST_STOP;
            end else rx_cnt_nx = rx_cnt + 1'b1;
            ST_STOP: if (rx_cnt == CNT_FULL) begin
                rx_state_nx = ST_IDLE;
                rx_valid    = srx_s;
            end else rx_cnt_nx = rx_cnt + 1'b1;
            default: rx_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_sh_nx    = tx_sh;
        int_clr     = '0;
        echo_take   = 1'b0;
        tx_irq_idx  = lowest_set(int_pend);
        unique case (tx_state)
            ST_IDLE: if (echo_valid) begin
                echo_take   = 1'b1;
                tx_sh_nx    = echo_byte;
                tx_cnt_nx   = '0;
                tx_state_nx = ST_START;
            end else if (|int_pend) begin
                int_clr[tx_irq_idx] = 1'b1;
                tx_sh_nx    = ASCII_BASE + {6'd0, tx_irq_idx};
                tx_cnt_nx   = '0;
                tx_state_nx = ST_START;
            end
            ST_START: if (tx_cnt == CNT_FULL) begin
                tx_cnt_nx   = '0;
                tx_bit_nx   = '0;
                tx_state_nx = ST_DATA;
            end else tx_cnt_nx = tx_cnt + 1'b1;
            ST_DATA: if (tx_cnt == CNT_FULL) begin
                tx_cnt_nx = '0;
                tx_sh_nx  = {1'b1, tx_sh[7:1]};
                tx_bit_nx = tx_bit + 1'b1;
                if (tx_bit == 3'd7) tx_state_nx = ST_STOP;
            end else tx_cnt_nx = tx_cnt + 1'b1;
            ST_STOP: if (tx_cnt == CNT_FULL) tx_state_nx = ST_IDLE;
                     else tx_cnt_nx = tx_cnt + 1'b1;
            default: tx_state_nx = ST_IDLE;
        endcase
        // Line level is registered from the next state to keep stx glitch-free.
        stx_nx = 1'b1;
        if (tx_state_nx == ST_START)     stx_nx = 1'b0;
        else if (tx_state_nx == ST_DATA) stx_nx = tx_sh_nx[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srx_d      <= 1'b1;
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_byte    <= '0;
            tx_state   <= ST_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_sh      <= '0;
            stx_q      <= 1'b1;
            echo_valid <= 1'b0;
            echo_byte  <= '0;
            led        <= '0;
        end else begin
            srx_d    <= srx_s;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_sh    <= rx_sh_nx;
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_sh    <= tx_sh_nx;
            stx_q    <= stx_nx;
            led      <= rx_byte;
            if (rx_valid) begin
                rx_byte    <= rx_sh;
                echo_valid <= 1'b1;
                echo_byte  <= rx_sh;
            end else if (echo_take) begin
                echo_valid <= 1'b0;
            end
        end
    end

    assign stx_pad_o = stx_q;
`else
    localparam int unsigned baud_div_unused = BAUD_DIV;

    logic [HB_W-1:0] hb;

    assign int_clr = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb  <= '0;
            led <= '0;
        end else begin
            hb  <= hb + 1'b1;
            led <= {int_pend, hb[HB_W-1 -: 5]};
        end
    end
`endif

endmodule

// File: tb/tb_fpga_wrapper.sv
// Self-checking bench for fpga_wrapper; covers the default build and, when
// UART_PER_EN is defined, the UART echo/report behaviour.
`timescale 1ns/1ps
module tb_fpga_wrapper;

    logic       clk_p = 1'b0;
    logic       clk_n;
    logic       rst_in;
    logic [2:0] int_in;
    logic [7:0] led;
    int         errors = 0;
    int         checks = 0;

    always #2.5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;

`ifdef UART_PER_EN
    logic       srx;
    logic       stx;
    logic [7:0] tx_seen[$];
    logic [7:0] exp_q[$];

    fpga_wrapper #(.BAUD_DIV(32), .HB_W(8), .SYNC_STAGES(2)) dut (
        .clk_in1_p (clk_p),
        .clk_in1_n (clk_n),
        .rst_in    (rst_in),
        .int_in    (int_in),
        .srx_pad_i (srx),
        .stx_pad_o (stx),
        .led       (led)
    );

    // Line monitor: decodes every frame on stx at mid-bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge stx);
            #80;
            for (int i = 0; i < 8; i++) begin
                #160;
                b[i] = stx;
            end
            #160;
            tx_seen.push_back(b);
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        srx = 1'b0;
        #160;
        for (int i = 0; i < 8; i++) begin
            srx = b[i];
            #160;
        end
        srx = stop_bit;
        #160;
        srx = 1'b1;
    endtask

    task automatic drain_and_compare(input string name, input int budget);
        int n;
        n = 0;
        while (tx_seen.size() < exp_q.size() && n < budget) begin
            @(posedge clk_p);
            n++;
        end
        if (tx_seen.size() < exp_q.size()) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d bytes, need %0d", name, tx_seen.size(), exp_q.size());
            exp_q.delete();
        end
        while (exp_q.size() > 0 && tx_seen.size() > 0) begin
            logic [7:0] e, a;
            e = exp_q.pop_front();
            a = tx_seen.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s byte: got %h, need %h", name, a, e);
            end
        end
    endtask
`else
    fpga_wrapper #(.BAUD_DIV(32), .HB_W(8), .SYNC_STAGES(2)) dut (
        .clk_in1_p (clk_p),
        .clk_in1_n (clk_n),
        .rst_in    (rst_in),
        .int_in    (int_in),
        .led       (led)
    );
`endif

    task automatic test_reset();
        rst_in = 1'b0;
        int_in = '0;
`ifdef UART_PER_EN
        srx = 1'b1;
`endif
        for (int k = 0; k < 4; k++) begin
            #50;
            checks++;
            if (led !== 8'h00) begin
                errors++;
                $display("FAIL reset_led: got %h, need 00", led);
            end
`ifdef UART_PER_EN
            checks++;
            if (stx !== 1'b1) begin
                errors++;
                $display("FAIL reset_stx: got %b, need 1", stx);
            end
`endif
        end
        @(posedge clk_p); #1;
        rst_in = 1'b1;
        @(posedge clk_p); #1;
        checks++;
        if (dut.rst_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_1clk: got %b, need 0", dut.rst_n);
        end
        @(posedge clk_p); #1;
        checks++;
        if (dut.rst_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_2clk: got %b, need 1", dut.rst_n);
        end
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_led: got %h, need 00", led);
        end
    endtask

`ifndef UART_PER_EN
    task automatic test_heartbeat();
        logic [4:0] prev, v;
        logic [4:0] hb_q[$];
        int         n;
        logic       wrapped;
        prev = led[4:0];
        n = 0;
        wrapped = 1'b0;
        while (led[4:0] === prev && n < 20) begin
            @(posedge clk_p); #1;
            n++;
        end
        checks++;
        if (led[4:0] === prev) begin
            errors++;
            $display("FAIL hb_start: led[4:0] stuck at %h", prev);
        end
        v = led[4:0];
        for (int k = 1; k <= 40; k++) hb_q.push_back(5'(v + k));
        while (hb_q.size() > 0) begin
            logic [4:0] e;
            repeat (8) @(posedge clk_p);
            #1;
            e = hb_q.pop_front();
            checks++;
            if (led !== {3'b000, e}) begin
                errors++;
                $display("FAIL hb_count: got %h, need %h", led, {3'b000, e});
            end
            if (led[4:0] === 5'd0) wrapped = 1'b1;
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL hb_wrap: got no wrap, need led[4:0] back to 0");
        end
    endtask

    task automatic test_interrupt();
        logic [2:0] exp_pend[$];
        int         seen;
        exp_pend.push_back(3'b100);
        exp_pend.push_back(3'b101);
        @(posedge clk_p); #1;
        int_in = 3'b100;
        seen = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk_p); #1;
            if (seen == 0 && led[7] === 1'b1) seen = i;
            if (i == 4) int_in = '0;
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL int2_latency: led[7] got %b after 4 clks, need 1", led[7]);
        end
        repeat (50) @(posedge clk_p);
        #1;
        begin
            logic [2:0] e;
            e = exp_pend.pop_front();
            checks++;
            if (led[7:5] !== e) begin
                errors++;
                $display("FAIL int2_sticky: got %b, need %b", led[7:5], e);
            end
        end
        int_in = 3'b001;
        @(posedge clk_p); #1;
        int_in = '0;
        repeat (5) @(posedge clk_p);
        #1;
        begin
            logic [2:0] e;
            e = exp_pend.pop_front();
            checks++;
            if (led[7:5] !== e) begin
                errors++;
                $display("FAIL int0_set: got %b, need %b", led[7:5], e);
            end
        end
        rst_in = 1'b0;
        #20;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_p);
        #1;
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL int_cleared_by_reset: got %h, need 00", led);
        end
    endtask
`else
    task automatic test_uart_echo();
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h67);
        send_frame(8'h61, 1'b1);
        #500;
        checks++;
        if (led !== 8'h61) begin
            errors++;
            $display("FAIL echo_led_61: got %h, need 61", led);
        end
        send_frame(8'h67, 1'b1);
        #300;
        checks++;
        if (led !== 8'h67) begin
            errors++;
            $display("FAIL echo_led_67: got %h, need 67", led);
        end
        drain_and_compare("echo", 2000);
    endtask

    task automatic test_uart_errors();
        #2000;
        tx_seen.delete();
        send_frame(8'h55, 1'b0);
        #400;
        checks++;
        if (led !== 8'h67) begin
            errors++;
            $display("FAIL framing_led: got %h, need 67", led);
        end
        srx = 1'b0;
        #40;
        srx = 1'b1;
        #3000;
        checks++;
        if (led !== 8'h67) begin
            errors++;
            $display("FAIL glitch_led: got %h, need 67", led);
        end
        checks++;
        if (tx_seen.size() != 0) begin
            errors++;
            $display("FAIL no_echo: got %0d bytes, need 0", tx_seen.size());
        end
    endtask

    task automatic test_uart_irq();
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        @(posedge clk_p); #1;
        int_in = 3'b011;
        repeat (4) @(posedge clk_p);
        #1;
        int_in = '0;
        drain_and_compare("irq", 2000);
        checks++;
        if (dut.int_pend !== 3'b000) begin
            errors++;
            $display("FAIL irq_pend_clear: got %b, need 000", dut.int_pend);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef UART_PER_EN
        test_uart_echo();
        test_uart_errors();
        test_uart_irq();
`else
        test_heartbeat();
        test_interrupt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
